// File: rtl/alarm_multi_ctrl.sv
// alarm_multi_ctrl: multi-slot HH:MM alarm with bounded ring, snooze, stop and fired-slot reporting
module alarm_multi_ctrl #(
    parameter int N_ALARMS    = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int IDXW        = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sec_tick,
    input  logic [3:0]          hour_ten,
    input  logic [3:0]          hour_one,
    input  logic [3:0]          minute_ten,
    input  logic [3:0]          minute_one,
    input  logic [3:0]          second_ten,
    input  logic [3:0]          second_one,
    input  logic                wr_en,
    input  logic [IDXW-1:0]     wr_idx,
    input  logic [15:0]         wr_time,
    input  logic                wr_arm,
    input  logic                snooze,
    input  logic                stop,
    output logic                bing,
    output logic                ringing,
    output logic                snoozing,
    output logic [IDXW-1:0]     ring_idx,
    output logic [N_ALARMS-1:0] armed
);
    localparam int CMAXV = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CW    = $clog2(CMAXV + 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [IDXW-1:0]     idx_q, idx_d, hit_idx;
    logic                hit, bing_q, wr_ok, disarm;
    logic [15:0]         time_q [N_ALARMS];
    logic [N_ALARMS-1:0] armed_q;
    logic [15:0]         now;

    assign now      = {hour_ten, hour_one, minute_ten, minute_one};
    assign wr_ok    = int'(wr_idx) < N_ALARMS;
    assign disarm   = wr_en && wr_ok && !wr_arm && wr_idx == idx_q;
    assign bing     = bing_q;
    assign ringing  = state_q == RING;
    assign snoozing = state_q == SNOOZE;
    assign ring_idx = idx_q;
    assign armed    = armed_q;

    // Top-of-minute compare against stored slots; scanning downward leaves the lowest match
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (sec_tick && second_ten == 4'd0 && second_one == 4'd0 && armed_q[i] && time_q[i] == now) begin
                hit     = 1'b1;
                hit_idx = IDXW'(i);
            end
        end
    end

    // Slot storage; compare above sees the pre-write contents
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= '0;
            for (int i = 0; i < N_ALARMS; i++) time_q[i] <= '0;
        end else if (wr_en && wr_ok) begin
            time_q[wr_idx]  <= wr_time;
            armed_q[wr_idx] <= wr_arm;
        end
    end

    // Next state: stop or disarm of the active slot beats snooze; ticks count seconds in RING/SNOOZE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = RING;
                    cnt_d   = '0;
                    idx_d   = hit_idx;
                end
            end
            RING: begin
                if (stop || disarm) begin
                    state_d = IDLE;
                end else if (snooze) begin
                    state_d = SNOOZE;
                    cnt_d   = '0;
                end else if (sec_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CW'(RING_SECS)) state_d = IDLE;
                end
            end
            SNOOZE: begin
                if (stop || disarm) begin
                    state_d = IDLE;
                end else if (sec_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CW'(SNOOZE_SECS)) begin
                        state_d = RING;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; bing is registered from next state so it beeps on even seconds of RING
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bing_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bing_q  <= state_d == RING && !cnt_d[0];
        end
    end
endmodule

// File: tb/tb_alarm_multi_ctrl.sv
// tb_alarm_multi_ctrl: scoreboard bench with a behavioural alarm model predicting every cycle
module tb_alarm_multi_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1, sec_tick = 1'b0, wr_en = 1'b0, wr_arm = 1'b0, snooze = 1'b0, stop = 1'b0;
    logic [3:0] hour_ten = '0, hour_one = '0, minute_ten = '0, minute_one = '0, second_ten = '0, second_one = '0;
    logic [1:0] wr_idx = '0;
    logic [15:0] wr_time = '0;
    logic       bing, ringing, snoozing;
    logic [1:0] ring_idx;
    logic [3:0] armed;

    always #5 clk = ~clk;

    alarm_multi_ctrl dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick),
        .hour_ten(hour_ten), .hour_one(hour_one), .minute_ten(minute_ten), .minute_one(minute_one),
        .second_ten(second_ten), .second_one(second_one),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_time(wr_time), .wr_arm(wr_arm),
        .snooze(snooze), .stop(stop),
        .bing(bing), .ringing(ringing), .snoozing(snoozing), .ring_idx(ring_idx), .armed(armed)
    );

    typedef struct {
        logic       bing;
        logic       ringing;
        logic       snoozing;
        logic [1:0] idx;
        logic [3:0] armed;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0, n_err = 0;
    int          m_st = 0, m_cnt = 0, m_idx = 0;
    logic [3:0]  m_arm = '0;
    logic [15:0] m_time [4] = '{default: '0};
    string       phase = "reset";

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour: 0 idle, 1 ringing, 2 snoozing; counts seconds since entering the state
    task automatic predict();
        exp_t e;
        int   hit;
        if (rst) begin
            m_st = 0; m_cnt = 0; m_idx = 0; m_arm = '0;
            for (int i = 0; i < 4; i++) m_time[i] = '0;
        end else begin
            hit = -1;
            if (sec_tick && second_ten == 0 && second_one == 0)
                for (int i = 0; i < 4; i++)
                    if (hit < 0 && m_arm[i] && m_time[i] == {hour_ten, hour_one, minute_ten, minute_one}) hit = i;
            if (m_st == 0) begin
                if (hit >= 0) begin m_st = 1; m_cnt = 0; m_idx = hit; end
            end else if (stop || (wr_en && !wr_arm && int'(wr_idx) == m_idx)) begin
                m_st = 0;
            end else if (m_st == 1 && snooze) begin
                m_st = 2; m_cnt = 0;
            end else if (sec_tick) begin
                m_cnt++;
                if (m_st == 1 && m_cnt >= 60) m_st = 0;
                else if (m_st == 2 && m_cnt >= 300) begin m_st = 1; m_cnt = 0; end
            end
            if (wr_en) begin
                m_time[wr_idx] = wr_time;
                m_arm[wr_idx]  = wr_arm;
            end
        end
        e.bing     = m_st == 1 && m_cnt % 2 == 0;
        e.ringing  = m_st == 1;
        e.snoozing = m_st == 2;
        e.idx      = 2'(m_idx);
        e.armed    = m_arm;
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        predict();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("bing", 32'(bing), 32'(e.bing));
        chk("ringing", 32'(ringing), 32'(e.ringing));
        chk("snoozing", 32'(snoozing), 32'(e.snoozing));
        chk("ring_idx", 32'(ring_idx), 32'(e.idx));
        chk("armed", 32'(armed), 32'(e.armed));
        sec_tick = 1'b0; wr_en = 1'b0; snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic set_time(int h, int m, int s);
        hour_ten   = 4'(h / 10); hour_one   = 4'(h % 10);
        minute_ten = 4'(m / 10); minute_one = 4'(m % 10);
        second_ten = 4'(s / 10); second_one = 4'(s % 10);
    endtask

    task automatic tick(int n);
        for (int k = 0; k < n; k++) begin
            sec_tick = 1'b1;
            cyc();
            cyc();
        end
    endtask

    task automatic wr(int idx, logic [15:0] t, logic arm);
        wr_en = 1'b1; wr_idx = 2'(idx); wr_time = t; wr_arm = arm;
    endtask

    initial begin
        cyc(); cyc();
        rst = 1'b0;
        phase = "basic";
        wr(2, 16'h0730, 1'b1); cyc();
        set_time(7, 29, 59); tick(1);
        set_time(7, 30, 0); tick(1);
        set_time(7, 30, 1); tick(61);
        phase = "priority";
        wr(1, 16'h0600, 1'b1); cyc();
        wr(3, 16'h0600, 1'b1); cyc();
        wr(0, 16'h0600, 1'b0); cyc();
        set_time(6, 0, 0); tick(1);
        stop = 1'b1; snooze = 1'b1; cyc(); cyc();
        phase = "snooze";
        tick(1);
        set_time(6, 0, 1); tick(3);
        snooze = 1'b1; cyc();
        tick(5);
        snooze = 1'b1; cyc();
        tick(296);
        tick(4);
        phase = "disarm";
        wr(1, 16'h0600, 1'b0); cyc(); cyc();
        phase = "prewrite";
        set_time(6, 0, 0); sec_tick = 1'b1; wr(3, 16'h0600, 1'b0); cyc(); cyc();
        tick(2);
        snooze = 1'b1; cyc();
        tick(2);
        stop = 1'b1; cyc(); cyc();
        phase = "nonzero_sec";
        set_time(7, 30, 5); tick(2);
        phase = "reset_mid";
        set_time(7, 30, 0); tick(1);
        set_time(7, 30, 1); tick(3);
        rst = 1'b1; cyc();
        rst = 1'b0; cyc();
        set_time(7, 30, 0); tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alarm_multi_ctrl.md
# alarm_multi_ctrl

Multi-slot alarm controller for the EDA digital clock: holds `N_ALARMS` independently programmable and armable HH:MM alarm times, compares them against the running BCD time once per second, and drives a beeping `bing` output. Compared with the single-compare alarm, it adds a bounded ring duration, snooze, stop, and reporting of which slot fired. It sits between the time counter chain (hour/minute/second BCD digits plus the 1 Hz tick) and the buzzer/LED driver. It runs on the fast system clock, with the 1 Hz tick used as an enable.

## Interface
- `N_ALARMS`, 4: number of alarm slots (1..16).
- `RING_SECS`, 60: seconds an alarm rings before auto-stop (≥2).
- `SNOOZE_SECS`, 300: snooze length in seconds (≥1).
- `IDXW`, `$clog2(N_ALARMS)` (min 1): slot index width (derived).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `sec_tick`  in  1  one-`clk` pulse per second; time inputs are stable and current on this cycle.
- `hour_ten`, `hour_one`, `minute_ten`, `minute_one`, `second_ten`, `second_one`  in  4 each  current time, BCD.
- `wr_en`  in  1  programming strobe.
- `wr_idx`  in  IDXW  slot to write.
- `wr_time`  in  16  {h_ten, h_one, m_ten, m_one}, BCD.
- `wr_arm`  in  1  arm bit written with `wr_time`.
- `snooze`  in  1  one-cycle pulse; snooze the active alarm.
- `stop`  in  1  one-cycle pulse; cancel the active alarm.
- `bing`  out  1  buzzer drive, registered.
- `ringing`  out  1  high in RING state.
- `snoozing`  out  1  high in SNOOZE state.
- `ring_idx`  out  IDXW  slot currently ringing or snoozed.
- `armed`  out  N_ALARMS  per-slot arm bits.

## Operation
- Slot storage: `N_ALARMS` × (16-bit time + arm bit). On `wr_en`, slot `wr_idx` is updated the next cycle. An out-of-range `wr_idx` is ignored. BCD validity is not checked.
- Match condition: `sec_tick`, `second_ten==0`, `second_one==0`, slot armed, and slot time == {hour_ten, hour_one, minute_ten, minute_one}. Matching uses pre-write slot contents if a write hits the same cycle.
- Priority: the lowest-index matching slot wins. Other simultaneous matches are dropped.
- FSM states:
  - IDLE: on match, go to RING, latch `ring_idx`, clear `sec_cnt`.
  - RING: `sec_cnt` increments on each `sec_tick`.
    - `stop` → IDLE.
    - else `snooze` → SNOOZE, clear `sec_cnt`.
    - else `sec_cnt` reaching `RING_SECS` → IDLE.
  - SNOOZE: `sec_cnt` increments on each `sec_tick`.
    - `stop` → IDLE.
    - `sec_cnt` reaching `SNOOZE_SECS` → RING, clear `sec_cnt`.
    - `snooze` is ignored.
- New matches in RING or SNOOZE are ignored; no queueing.
- Writing `wr_arm=0` to slot `ring_idx` while in RING or SNOOZE forces IDLE the next cycle. Writing `wr_arm=1` or a new time does not affect the active alarm.
- `stop` and `snooze` in the same cycle: `stop` wins. Both pulses are ignored in IDLE.
- `bing` = RING and `sec_cnt[0]==0`, registered, giving a 1 s on / 1 s off beep that starts "on".
- `sec_cnt` is `$clog2(max(RING_SECS, SNOOZE_SECS)+1)` bits wide and saturates; it never wraps.

## Timing
- Reset values:
  - all slot times 0000, `armed`=0;
  - state IDLE, `sec_cnt`=0;
  - `bing`=0, `ringing`=0, `snoozing`=0, `ring_idx`=0.
- Reset mid-ring or mid-snooze returns all of the above on the next cycle.
- Match on cycle T (the `sec_tick` at HH:MM:00): `ringing`=1 and `bing`=1 at T+1.
- `bing` toggles one cycle after each subsequent `sec_tick`.
- Auto-stop: the `RING_SECS`-th `sec_tick` after entry; `ringing`=0 and `bing`=0 one cycle later.
- `stop`/`snooze` on cycle C: state and outputs change at C+1. `bing`=0 at C+1.
- Snooze expiry: the `SNOOZE_SECS`-th `sec_tick` after entry; RING with `bing`=1 one cycle later.
- A `sec_tick` on the same cycle as `stop`/`snooze`/entry is not counted toward the new state.

## Test plan
- Program slot 2 = 07:30 armed, drive time 07:29:59→07:30:00 with `sec_tick` → `ringing`=1, `ring_idx`=2, `bing`=1 one cycle after the tick; `bing` alternates each second and `ringing` drops after 60 ticks.
- Slots 1 and 3 both 06:00 armed → `ring_idx`=1 only. Slot disarmed at the same time → no ring.
- Ring, then `snooze` pulse → `snoozing`=1, `bing`=0. After 300 ticks → `ringing`=1, `bing`=1, same `ring_idx`.
- `stop` and `snooze` in the same cycle during RING → IDLE. Disarm the ringing slot via write → IDLE the next cycle.
- Assert `rst` mid-RING → all outputs 0 next cycle, `armed`=0. A match with `second_one`≠0 (e.g. 07:30:05) never triggers.
